game_state_ctrl: RTL and testbench
==================================

Name: game_state_ctrl

Overview:
- Top-level game sequencer.
- Drives the 4-bit state bus that phase modules (menu, play, result) watch for entry edges.
- Consumes each phase module's busy/finished handshake to advance the game.
- Registers a per-state pixel mux for the video path.

Parameters:
START_TIMEOUT, 1024, cycles a phase may go without raising its busy before the controller retries entry (1..65535)
ROUND_W, 8, width of round counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
menu_busy_in  input  1  menu phase busy
menu_finished_in  input  1  menu phase done, 1-cycle pulse
play_busy_in  input  1  play phase busy
play_finished_in  input  1  play phase done (game over), 1-cycle pulse
result_busy_in  input  1  result phase busy
result_finished_in  input  1  result phase done, 1-cycle pulse
btn_in  input  1  skip button, debounced level
menu_pixel_in  input  12  menu pixel
play_pixel_in  input  12  play pixel
result_pixel_in  input  12  result pixel
state_out  output  4  current game state
state_changed_out  output  1  1-cycle pulse on the cycle state_out takes a new value
round_count_out  output  ROUND_W  completed rounds
pixel_out  output  12  registered pixel for current state

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- State encodings:
  - BOOT = 4'b1010
  - MENU = 4'b0000
  - PLAY = 4'b0001
  - RESULT = 4'b0010
  - No other values are ever driven.
- Reset values: state_out=BOOT, state_changed_out=0, round_count_out=0, pixel_out=12'h000; timer, busy_seen and the btn edge register are cleared.
- Reset mid-operation has the same effect, regardless of phase activity.
- BOOT:
  - Lasts exactly one cycle; the next cycle goes to the pending target.
  - Target is MENU after reset, or the retried state after a watchdog retry.
  - This gives phase modules a guaranteed state change into their code.
- Transitions, evaluated on the cycle after a qualifying input:
  - MENU: menu_finished_in -> PLAY.
  - PLAY: play_finished_in -> RESULT; round_count_out += 1, wrapping at 2^ROUND_W-1 -> 0.
  - RESULT: result_finished_in or btn rising edge -> MENU. Both on the same cycle count as one transition.
  - btn edge in MENU, PLAY or BOOT is ignored.
  - A finished_in from a module not owning the current state is ignored.
  - finished_in on the first cycle of a state (state_changed_out=1) is ignored.
- state_changed_out:
  - High exactly on the first cycle of each new state value, including BOOT->MENU after reset.
  - Never high two consecutive cycles except BOOT->X.
- Watchdog:
  - On entry to MENU/PLAY/RESULT, timer=0 and busy_seen=0.
  - Each cycle: if the owning busy_in=1, set busy_seen; else if !busy_seen, timer += 1.
  - When timer reaches START_TIMEOUT with busy_seen=0, go to BOOT (target = same state) and do not change round count.
  - Once busy_seen=1, the watchdog is disabled for that state visit.
  - finished_in takes priority over a same-cycle timeout.
- Button edge: btn registered once; edge = btn_in & ~btn_q.
  - A held button produces one edge.
  - An edge arriving while not in RESULT is discarded, not queued.
- Pixel path:
  - pixel_out registered, 1-cycle latency from state_out.
  - MENU -> menu_pixel_in, PLAY -> play_pixel_in, RESULT -> result_pixel_in, BOOT -> 12'h000.
- At most one state transition per cycle.

Test Plan:
- Reset and boot sequence: rst high 3 cycles then low.
  - During reset: state_out=1010.
  - First cycle after release: 1010.
  - Next cycle: 0000 with state_changed_out=1 for exactly one cycle.
  - round_count_out=0.
- Full round: menu_busy high, then a menu_finished pulse -> PLAY next cycle; play_busy high, then a play_finished pulse -> RESULT, round_count_out=1; result_finished pulse -> MENU. Repeat 256 rounds -> round_count_out wraps to 0.
- Skip and stray pulses:
  - In RESULT, hold btn_in for 10 cycles -> single transition to MENU.
  - Pulse play_finished_in while in MENU -> state stays 0000.
  - Button edge in PLAY -> no change.
  - Button and result_finished on the same cycle -> one MENU entry.
- Watchdog (START_TIMEOUT=16): enter PLAY with play_busy_in held 0.
  - After 16 cycles -> 1010 for one cycle, then 0001 again.
  - Raising busy at cycle 15 -> no retry ever.
  - play_finished on the timeout cycle -> RESULT, not BOOT.
- Pixel mux: menu/play/result pixels = 12'h111/12'h222/12'h333.
  - pixel_out follows state_out one cycle late.
  - pixel_out=000 during BOOT.
- Mid-game reset: rst pulsed while in PLAY with round_count_out=5 -> state_out=1010, round_count_out=0, pixel_out=000, then MENU.

Source files
------------

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: top-level game sequencer driving the phase state bus, start watchdog and per-state pixel mux.
module game_state_ctrl #(
  parameter int START_TIMEOUT = 1024,
  parameter int ROUND_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               menu_busy_in,
  input  logic               menu_finished_in,
  input  logic               play_busy_in,
  input  logic               play_finished_in,
  input  logic               result_busy_in,
  input  logic               result_finished_in,
  input  logic               btn_in,
  input  logic [11:0]        menu_pixel_in,
  input  logic [11:0]        play_pixel_in,
  input  logic [11:0]        result_pixel_in,
  output logic [3:0]         state_out,
  output logic               state_changed_out,
  output logic [ROUND_W-1:0] round_count_out,
  output logic [11:0]        pixel_out
);
  typedef enum logic [3:0] {
    BOOT   = 4'b1010,
    MENU   = 4'b0000,
    PLAY   = 4'b0001,
    RESULT = 4'b0010
  } state_t;
  state_t r_state, r_target, w_next, w_target;
  logic [15:0] r_timer;
  logic r_seen, r_btn, r_changed;
  logic [ROUND_W-1:0] r_round;
  logic [11:0] r_pixel;
  logic w_edge, w_busy, w_fin, w_tout;
  always_comb begin
    w_edge = btn_in & ~r_btn;
    w_busy = r_state == MENU ? menu_busy_in : r_state == PLAY ? play_busy_in :
             r_state == RESULT ? result_busy_in : 1'b0;
    // a finished pulse on a state's first cycle belongs to the previous visit
    w_fin = ~r_changed & (r_state == MENU ? menu_finished_in : r_state == PLAY ? play_finished_in :
                          r_state == RESULT ? result_finished_in : 1'b0);
    w_tout = r_state != BOOT && !r_seen && !w_busy && r_timer == 16'(START_TIMEOUT - 1);
    w_next = r_state;
    w_target = r_target;
    if (r_state == BOOT) w_next = r_target;
    else if (w_fin) w_next = r_state == MENU ? PLAY : r_state == PLAY ? RESULT : MENU;
    else if (r_state == RESULT && w_edge) w_next = MENU;
    else if (w_tout) begin
      w_next = BOOT;
      w_target = r_state;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= BOOT;
      r_target  <= MENU;
      r_changed <= 1'b0;
      r_round   <= '0;
      r_pixel   <= 12'h000;
      r_timer   <= '0;
      r_seen    <= 1'b0;
      r_btn     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_target  <= w_target;
      r_changed <= w_next != r_state;
      r_btn     <= btn_in;
      if (r_state == PLAY && w_fin) r_round <= r_round + ROUND_W'(1);
      r_pixel <= r_state == MENU ? menu_pixel_in : r_state == PLAY ? play_pixel_in :
                 r_state == RESULT ? result_pixel_in : 12'h000;
      if (w_next != r_state) begin
        r_timer <= '0;
        r_seen  <= 1'b0;
      end else if (w_busy) r_seen <= 1'b1;
      else if (!r_seen) r_timer <= r_timer + 16'd1;
    end
  end
  assign state_out = r_state;
  assign state_changed_out = r_changed;
  assign round_count_out = r_round;
  assign pixel_out = r_pixel;
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: vector table plus hand sequences, expectations queued at drive time and checked after each edge.
module tb_game_state_ctrl;
  localparam logic [3:0] BOOT = 4'b1010, MENU = 4'b0000, PLAY = 4'b0001, RESULT = 4'b0010;
  logic clk = 1'b0;
  logic rst = 1'b1, mb = 1'b0, mf = 1'b0, pb = 1'b0, pf = 1'b0, rb = 1'b0, rf = 1'b0, btn = 1'b0;
  logic [3:0] st;
  logic ch;
  logic [7:0] rc;
  logic [11:0] px;
  int checks = 0, errors = 0;
  typedef struct {logic [3:0] st; logic ch; logic [7:0] rd; logic [11:0] px;} exp_t;
  typedef struct {logic [7:0] in; logic [3:0] st;} vec_t;
  exp_t q[$];
  exp_t ce;
  vec_t tbl[$];
  logic [3:0] pst = BOOT;
  logic [7:0] rd = 8'd0;
  always #5 clk = ~clk;
  game_state_ctrl #(.START_TIMEOUT(16), .ROUND_W(8)) dut (
    .clk(clk), .rst(rst),
    .menu_busy_in(mb), .menu_finished_in(mf),
    .play_busy_in(pb), .play_finished_in(pf),
    .result_busy_in(rb), .result_finished_in(rf),
    .btn_in(btn),
    .menu_pixel_in(12'h111), .play_pixel_in(12'h222), .result_pixel_in(12'h333),
    .state_out(st), .state_changed_out(ch), .round_count_out(rc), .pixel_out(px)
  );
  function automatic logic [11:0] pix(logic [3:0] s);
    return s == MENU ? 12'h111 : s == PLAY ? 12'h222 : s == RESULT ? 12'h333 : 12'h000;
  endfunction
  function automatic vec_t v(logic [7:0] in, logic [3:0] s);
    vec_t r;
    r.in = in;
    r.st = s;
    return r;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      ce = q.pop_front();
      chk("state", 32'(st), 32'(ce.st));
      chk("changed", 32'(ch), 32'(ce.ch));
      chk("round", 32'(rc), 32'(ce.rd));
      chk("pixel", 32'(px), 32'(ce.px));
    end
  end
  // in = {rst, menu_busy, menu_fin, play_busy, play_fin, result_busy, result_fin, btn}
  task automatic drive(logic [7:0] in, logic [3:0] es);
    exp_t e;
    @(negedge clk);
    {rst, mb, mf, pb, pf, rb, rf, btn} = in;
    e.st = es;
    e.ch = in[7] ? 1'b0 : es != pst;
    e.rd = in[7] ? 8'd0 : (pst == PLAY && es == RESULT) ? rd + 8'd1 : rd;
    e.px = in[7] ? 12'h000 : pix(pst);
    q.push_back(e);
    pst = es;
    rd = e.rd;
  endtask
  task automatic round_trip();
    drive(8'h60, PLAY);
    drive(8'h10, PLAY);
    drive(8'h18, RESULT);
    drive(8'h04, RESULT);
    drive(8'h06, MENU);
    drive(8'h40, MENU);
  endtask
  initial begin
    tbl.push_back(v(8'h80, BOOT)); tbl.push_back(v(8'h80, BOOT)); tbl.push_back(v(8'h80, BOOT));
    tbl.push_back(v(8'h00, MENU)); tbl.push_back(v(8'h40, MENU)); tbl.push_back(v(8'h60, PLAY));
    tbl.push_back(v(8'h18, PLAY)); tbl.push_back(v(8'h10, PLAY)); tbl.push_back(v(8'h18, RESULT));
    tbl.push_back(v(8'h04, RESULT)); tbl.push_back(v(8'h06, MENU)); tbl.push_back(v(8'h48, MENU));
    tbl.push_back(v(8'h60, PLAY)); tbl.push_back(v(8'h10, PLAY)); tbl.push_back(v(8'h11, PLAY));
    tbl.push_back(v(8'h11, PLAY)); tbl.push_back(v(8'h18, RESULT)); tbl.push_back(v(8'h04, RESULT));
    tbl.push_back(v(8'h05, MENU));
    for (int i = 0; i < 9; i++) tbl.push_back(v(8'h41, MENU));
    tbl.push_back(v(8'h40, MENU)); tbl.push_back(v(8'h60, PLAY)); tbl.push_back(v(8'h10, PLAY));
    tbl.push_back(v(8'h18, RESULT)); tbl.push_back(v(8'h04, RESULT)); tbl.push_back(v(8'h07, MENU));
    tbl.push_back(v(8'h40, MENU)); tbl.push_back(v(8'h40, MENU));
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i].in, tbl[i].st);
    for (int i = 0; i < 253; i++) round_trip();
    chk("round_wrap", 32'(rc), 32'd0);
    drive(8'h60, PLAY);
    for (int i = 0; i < 15; i++) drive(8'h00, PLAY);
    drive(8'h00, BOOT);
    drive(8'h00, PLAY);
    for (int i = 0; i < 15; i++) drive(8'h00, PLAY);
    drive(8'h10, PLAY);
    for (int i = 0; i < 20; i++) drive(8'h00, PLAY);
    drive(8'h08, RESULT);
    drive(8'h04, RESULT);
    drive(8'h06, MENU);
    drive(8'h40, MENU);
    drive(8'h60, PLAY);
    for (int i = 0; i < 15; i++) drive(8'h00, PLAY);
    drive(8'h08, RESULT);
    drive(8'h04, RESULT);
    drive(8'h06, MENU);
    drive(8'h40, MENU);
    for (int i = 0; i < 3; i++) round_trip();
    drive(8'h60, PLAY);
    drive(8'h10, PLAY);
    chk("mid_round", 32'(rc), 32'd5);
    chk("mid_state", 32'(st), 32'(PLAY));
    drive(8'h90, BOOT);
    drive(8'h00, MENU);
    drive(8'h40, MENU);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
